// File: rtl/srrc_mac_sched_pkg.sv
// srrc_sched_pkg: shared SRRC MAC scheduler parameters, size derivations and state encoding.
package srrc_sched_pkg;
    localparam int DEF_NUM_TAPS = 305;
    localparam int DEF_NUM_MAC  = 8;
    localparam int DEF_PIPE_LAT = 3;

    typedef enum logic [1:0] {IDLE, RUN_I, RUN_Q} state_t;

    function automatic int nuniq(input int taps);
        return (taps + 1) / 2;
    endfunction

    function automatic int ngrp(input int taps, input int macs);
        return (nuniq(taps) + macs - 1) / macs;
    endfunction

    // grp stays at least 5 bits wide so the default port width is kept
    function automatic int grp_w(input int groups);
        return $clog2(groups) > 5 ? $clog2(groups) : 5;
    endfunction
endpackage

// File: rtl/srrc_mac_sched_if.sv
// srrc_mac_sched_if: strobe inputs plus issue/accumulator/result outputs of the MAC scheduler.
interface srrc_mac_sched_if
    import srrc_sched_pkg::*;
#(
    parameter int NUM_MAC = DEF_NUM_MAC,
    parameter int GW      = grp_w(ngrp(DEF_NUM_TAPS, DEF_NUM_MAC))
);
    logic               sam_clk_en;
    logic               sym_clk_en;
    logic               clr_overrun;
    logic [GW-1:0]      grp;
    logic [NUM_MAC-1:0] lane_mask;
    logic               iss_ch;
    logic               iss_vld;
    logic               acc_clr;
    logic               acc_en;
    logic               acc_ch;
    logic               ld_i;
    logic               ld_q;
    logic               out_valid;
    logic               out_sym;
    logic               busy;
    logic               overrun;

    modport slave (
        input  sam_clk_en, sym_clk_en, clr_overrun,
        output grp, lane_mask, iss_ch, iss_vld, acc_clr, acc_en, acc_ch,
               ld_i, ld_q, out_valid, out_sym, busy, overrun
    );
    modport master (
        output sam_clk_en, sym_clk_en, clr_overrun,
        input  grp, lane_mask, iss_ch, iss_vld, acc_clr, acc_en, acc_ch,
               ld_i, ld_q, out_valid, out_sym, busy, overrun
    );
endinterface

// File: rtl/srrc_mac_sched_ctrl_delay_line.sv
// ctrl_delay_line: DEPTH-stage reset-cleared shift of issue control bits; MSB is the valid flag.
module ctrl_delay_line #(
    parameter int W     = 5,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         any_vld
);
    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_vld = any_vld | sr[i][W-1];
    end

    assign dout = sr[DEPTH-1];
endmodule

// File: rtl/srrc_mac_sched.sv
// srrc_mac_sched: schedules NGRP coefficient groups per channel (I then Q) per accepted sample
// over NUM_MAC shared multipliers, with delayed accumulator control and result strobes.
module srrc_mac_sched
    import srrc_sched_pkg::*;
#(
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int NUM_MAC  = DEF_NUM_MAC,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input logic                clk,
    input logic                reset,
    srrc_mac_sched_if.slave    s
);
    localparam int NUNIQ      = nuniq(NUM_TAPS);
    localparam int NGRP       = ngrp(NUM_TAPS, NUM_MAC);
    localparam int GW         = grp_w(NGRP);
    localparam int LAST_LANES = NUNIQ - (NGRP - 1) * NUM_MAC;
    localparam logic [NUM_MAC-1:0] LAST_MASK = {NUM_MAC{1'b1}} >> (NUM_MAC - LAST_LANES);

    state_t        state, state_nx;
    logic [GW-1:0] grp_r, grp_nx;
    logic          run, last, sym_lat;
    logic [4:0]    dl_in, dl_out;
    logic          dl_pend;
    logic          ld_i_r, ld_q_r, ld_q_sym, out_valid_r, out_sym_r, ovr_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grp_r   <= '0;
            sym_lat <= 1'b0;
        end else begin
            state <= state_nx;
            grp_r <= grp_nx;
            if (state == IDLE && s.sam_clk_en) sym_lat <= s.sym_clk_en;
        end
    end

    always_comb begin
        run      = state != IDLE;
        last     = run && grp_r == GW'(NGRP - 1);
        state_nx = state == IDLE ? (s.sam_clk_en ? RUN_I : IDLE) :
                   !last         ? state :
                   state == RUN_I ? RUN_Q : IDLE;
        grp_nx   = (run && !last) ? grp_r + 1'b1 : '0;
    end

    // {vld, ch, first group, last group, symbol flag}; the flag travels with its own
    // schedule so a sample accepted during the drain cannot overwrite it
    assign dl_in = {run, state == RUN_Q, run && grp_r == '0, last, sym_lat};

    ctrl_delay_line #(.W(5), .DEPTH(PIPE_LAT)) u_dly (
        .clk     (clk),
        .reset   (reset),
        .din     (dl_in),
        .dout    (dl_out),
        .any_vld (dl_pend)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_i_r      <= 1'b0;
            ld_q_r      <= 1'b0;
            ld_q_sym    <= 1'b0;
            out_valid_r <= 1'b0;
            out_sym_r   <= 1'b0;
            ovr_r       <= 1'b0;
        end else begin
            ld_i_r      <= dl_out[4] & dl_out[1] & ~dl_out[3];
            ld_q_r      <= dl_out[4] & dl_out[1] & dl_out[3];
            ld_q_sym    <= dl_out[4] & dl_out[1] & dl_out[3] & dl_out[0];
            out_valid_r <= ld_q_r;
            out_sym_r   <= ld_q_sym;
            ovr_r       <= (run & s.sam_clk_en) | (ovr_r & ~s.clr_overrun);
        end
    end

    assign s.grp       = grp_r;
    assign s.lane_mask = !run ? '0 : last ? LAST_MASK : '1;
    assign s.iss_vld   = run;
    assign s.iss_ch    = state == RUN_Q;
    assign s.acc_en    = dl_out[4];
    assign s.acc_ch    = dl_out[3];
    assign s.acc_clr   = dl_out[4] & dl_out[2];
    assign s.ld_i      = ld_i_r;
    assign s.ld_q      = ld_q_r;
    assign s.out_valid = out_valid_r;
    assign s.out_sym   = out_sym_r;
    assign s.busy      = run | dl_pend | ld_i_r | ld_q_r | out_valid_r;
    assign s.overrun   = ovr_r;
endmodule
